store_queue_fwd: RTL

- Parametrised store queue for the out-of-order back end. Successor to the single-entry-per-cycle store path in the LSQ.
- Accepts up to ALLOC_W stores per cycle from dispatch and captures address+data from the AGU by tag.
- Marks stores committed in program order from the ROB and drains committed stores to the data cache with a valid/ready handshake.
- Provides combinational store-to-load forwarding to the load pipe.

---
 rtl/store_queue_fwd.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/store_queue_fwd.sv
// Store queue with in-order commit, cache drain and store-to-load forwarding.
// Define STQ_FWD_EN for data forwarding; otherwise loads that may alias a store stall.
module store_queue_fwd #(
    parameter int DEPTH   = 8,
    parameter int ALLOC_W = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [ALLOC_W-1:0]         alloc_valid,
    input  logic [ALLOC_W*TAG_W-1:0]   alloc_tag,
    output logic [ALLOC_W-1:0]         alloc_rdy,
    input  logic                       agu_valid,
    input  logic [TAG_W-1:0]           agu_tag,
    input  logic [ADDR_W-1:0]          agu_addr,
    input  logic [DATA_W-1:0]          agu_data,
    input  logic                       commit_valid,
    output logic                       mem_req_valid,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [DATA_W-1:0]          mem_req_data,
    input  logic                       mem_req_rdy,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_fwd_hit,
    output logic [DATA_W-1:0]          ld_fwd_data,
    output logic                       ld_stall,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Index plus wrap bit; the wrap bit disambiguates full from empty.
    typedef struct packed {
        logic          w;
        logic [IW-1:0] idx;
    } ptr_t;

    function automatic ptr_t ptr_add(ptr_t p, logic [PW-1:0] n);
        logic [PW-1:0] s;
        ptr_t          r;
        s = {1'b0, p.idx} + n;
        r = p;
        if (s >= PW'(DEPTH)) begin
            s     = s - PW'(DEPTH);
            r.w   = ~p.w;
        end
        r.idx = s[IW-1:0];
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_dist(ptr_t a, ptr_t b);
        if (a.w == b.w)
            return {1'b0, a.idx} - {1'b0, b.idx};
        else
            return {1'b0, a.idx} + PW'(DEPTH) - {1'b0, b.idx};
    endfunction

    ptr_t head_q, head_d;
    ptr_t cmt_q, cmt_d;
    ptr_t tail_q, tail_d;

    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DEPTH-1:0]  res_q, res_d;
    logic [DEPTH-1:0]  com_q, com_d;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic [PW-1:0]      occ;
    logic [PW-1:0]      free_slots;
    logic [ALLOC_W-1:0] acc;
    logic [PW-1:0]      n_acc;
    logic               acc_run;
    ptr_t               alloc_ptr [ALLOC_W];
    logic [DEPTH-1:0]   agu_hit;
    logic               commit_ok;
    logic               drain_fire;

    assign occ        = ptr_dist(tail_q, head_q);
    assign free_slots = PW'(DEPTH) - occ;
    assign count      = CW'(occ);

    assign mem_req_valid = vld_q[head_q.idx] & com_q[head_q.idx];
    assign mem_req_addr  = addr_q[head_q.idx];
    assign mem_req_data  = data_q[head_q.idx];
    assign drain_fire    = mem_req_valid & mem_req_rdy;

    assign commit_ok = commit_valid & (cmt_q != tail_q);

    // Readiness per port from registered occupancy; accepted ports form a prefix.
    always_comb begin
        alloc_rdy = '0;
        acc       = '0;
        n_acc     = '0;
        acc_run   = ~flush;
        for (int i = 0; i < ALLOC_W; i++) begin
            alloc_rdy[i] = (free_slots >= PW'(i + 1));
            acc_run      = acc_run & alloc_valid[i] & alloc_rdy[i];
            acc[i]       = acc_run;
            n_acc        = n_acc + PW'(acc_run);
            alloc_ptr[i] = ptr_add(tail_q, PW'(i));
        end
    end

    // AGU result targets the live, not-yet-committed entry carrying its tag.
    always_comb begin
        agu_hit = '0;
        for (int j = 0; j < DEPTH; j++)
            agu_hit[j] = agu_valid & vld_q[j] & ~com_q[j]
                       & (tag_q[j] == agu_tag);
    end

    // Next-state for pointers and entries: drain, then flush or alloc/AGU/commit.
    always_comb begin
        head_d = head_q;
        cmt_d  = cmt_q;
        tail_d = tail_q;
        vld_d  = vld_q;
        res_d  = res_q;
        com_d  = com_q;
        tag_d  = tag_q;
        addr_d = addr_q;
        data_d = data_q;

        if (drain_fire) begin
            vld_d[head_q.idx] = 1'b0;
            res_d[head_q.idx] = 1'b0;
            com_d[head_q.idx] = 1'b0;
            head_d            = ptr_add(head_q, PW'(1));
        end

        if (flush) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (vld_q[j] && !com_q[j]) begin
                    vld_d[j] = 1'b0;
                    res_d[j] = 1'b0;
                end
            end
            tail_d = cmt_q;
        end else begin
            for (int i = 0; i < ALLOC_W; i++) begin
                if (acc[i]) begin
                    vld_d[alloc_ptr[i].idx] = 1'b1;
                    res_d[alloc_ptr[i].idx] = 1'b0;
                    com_d[alloc_ptr[i].idx] = 1'b0;
                    tag_d[alloc_ptr[i].idx] = alloc_tag[i*TAG_W +: TAG_W];
                end
            end
            tail_d = ptr_add(tail_q, n_acc);

            for (int j = 0; j < DEPTH; j++) begin
                if (agu_hit[j]) begin
                    res_d[j]  = 1'b1;
                    addr_d[j] = agu_addr;
                    data_d[j] = agu_data;
                end
            end

            if (commit_ok) begin
                com_d[cmt_q.idx] = 1'b1;
                cmt_d            = ptr_add(cmt_q, PW'(1));
            end
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
            vld_q  <= '0;
            res_q  <= '0;
            com_q  <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
            vld_q  <= vld_d;
            res_q  <= res_d;
            com_q  <= com_d;
        end
    end

    // Payload storage is qualified by the valid bits and needs no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        addr_q <= addr_d;
        data_q <= data_d;
    end

`ifdef STQ_FWD_EN
    logic [PW-1:0] scan_pos;
    logic [IW-1:0] scan_idx;

    // Walk oldest to youngest so the youngest relevant store decides.
    always_comb begin
        ld_fwd_hit  = 1'b0;
        ld_fwd_data = '0;
        ld_stall    = 1'b0;
        scan_pos    = '0;
        scan_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_pos = {1'b0, head_q.idx} + PW'(k);
            if (scan_pos >= PW'(DEPTH))
                scan_pos = scan_pos - PW'(DEPTH);
            scan_idx = scan_pos[IW-1:0];
            if (vld_q[scan_idx]) begin
                if (!res_q[scan_idx]) begin
                    ld_stall    = 1'b1;
                    ld_fwd_hit  = 1'b0;
                    ld_fwd_data = '0;
                end else if (addr_q[scan_idx] == ld_addr) begin
                    ld_stall    = 1'b0;
                    ld_fwd_hit  = 1'b1;
                    ld_fwd_data = data_q[scan_idx];
                end
            end
        end
        if (!ld_valid) begin
            ld_fwd_hit  = 1'b0;
            ld_fwd_data = '0;
            ld_stall    = 1'b0;
        end
    end
`else
    // Without forwarding, any possible alias or unknown address replays the load.
    always_comb begin
        ld_fwd_hit  = 1'b0;
        ld_fwd_data = '0;
        ld_stall    = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (vld_q[j] && (!res_q[j] || addr_q[j] == ld_addr))
                ld_stall = 1'b1;
        end
        if (!ld_valid)
            ld_stall = 1'b0;
    end
`endif

    a_commit_resolved : assert property (
        @(posedge clk) disable iff (rst)
        (commit_ok && !flush) |-> res_q[cmt_q.idx]
    );

endmodule
